// File: rtl/muldiv_pkg.sv
// Shared definitions for the MULT/DIV/MTHI/MTLO execute-stage unit:
// ex_op encodings, controller state encoding and default timing constants.
package muldiv_pkg;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MUL_CYCLES_DEF  = 4;
    localparam int DIV_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_hilo_unit_hilo_regs.sv
// Architectural HI/LO register pair. A multiply/divide completion writes
// both halves and wins over MTHI/MTLO; MTHI and MTLO each write one half.
module hilo_regs (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmp_we,
    input  logic [31:0] cmp_hi,
    input  logic [31:0] cmp_lo,
    input  logic        hi_we,
    input  logic [31:0] hi_data,
    input  logic        lo_we,
    input  logic [31:0] lo_data,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    // HI/LO storage with completion-first write priority
    always_ff @(posedge clock) begin
        if (reset) begin
            hi_o <= 32'd0;
            lo_o <= 32'd0;
        end else if (cmp_we) begin
            hi_o <= cmp_hi;
            lo_o <= cmp_lo;
        end else begin
            if (hi_we) hi_o <= hi_data;
            if (lo_we) lo_o <= lo_data;
        end
    end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// EX-stage controller for MULT/MULTU/DIV/DIVU/MTHI/MTLO. Stalls the
// pipeline while a multiply counts down or the external divider runs,
// then writes the result into HI/LO. Handshake with the divider:
// div_start is a registered level, raised at issue and held (with stable
// div_op1/div_op2/div_unsigned) until the div_done pulse, a flush, or the
// busy timeout; it always drops for at least one cycle between divides.
// Optional build macro MULDIV_DIVZERO_FAST_EN: a divide by zero retires in
// its issue cycle without starting the divider and leaves HI/LO unchanged.
module muldiv_hilo_unit
    import muldiv_pkg::*;
#(
    parameter int MUL_CYCLES  = MUL_CYCLES_DEF,
    parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [2:0]  ex_op,
    input  logic [31:0] ex_rs_data,
    input  logic [31:0] ex_rt_data,
    input  logic        flush,
    output logic        stall_out,
    output logic        div_start,
    output logic        div_unsigned,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    input  logic [63:0] div_result,
    input  logic        div_done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam int BCW = $clog2(DIV_TIMEOUT + 1);
    localparam logic [MCW-1:0] MUL_LOAD  = MCW'(MUL_CYCLES - 1);
    localparam logic [BCW-1:0] BUSY_LAST = BCW'(DIV_TIMEOUT - 1);

    state_e         state, state_next;
    logic [MCW-1:0] mul_cnt;
    logic [BCW-1:0] busy_cnt;
    logic [31:0]    mul_a, mul_b;
    logic           mul_signed;
    logic [63:0]    mul_a_ext, mul_b_ext, product;
    logic           is_mul, is_div;
    logic           issue_mul, issue_div;
    logic           hi_we, lo_we, cmp_we;
    logic [31:0]    cmp_hi, cmp_lo;

    assign is_mul = (ex_op == OP_MULT) || (ex_op == OP_MULTU);
    assign is_div = (ex_op == OP_DIV)  || (ex_op == OP_DIVU);

    // Sign- or zero-extended operands give the 33x33 signed product's low 64 bits
    assign mul_a_ext = {{32{mul_signed & mul_a[31]}}, mul_a};
    assign mul_b_ext = {{32{mul_signed & mul_b[31]}}, mul_b};
    assign product   = mul_a_ext * mul_b_ext;

    // Next state, stall and write decisions; flush always wins over completion
    always_comb begin
        state_next = state;
        stall_out  = 1'b0;
        issue_mul  = 1'b0;
        issue_div  = 1'b0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        cmp_we     = 1'b0;
        cmp_hi     = 32'd0;
        cmp_lo     = 32'd0;
        case (state)
            IDLE: begin
                if (ex_valid && !flush) begin
                    if (is_mul) begin
                        stall_out  = 1'b1;
                        issue_mul  = 1'b1;
                        state_next = MUL_BUSY;
                    end else if (is_div) begin
`ifdef MULDIV_DIVZERO_FAST_EN
                        if (ex_rt_data == 32'd0) begin
                            // retires in place: no divider run, no write
                        end else
`endif
                        begin
                            stall_out  = 1'b1;
                            issue_div  = 1'b1;
                            state_next = DIV_BUSY;
                        end
                    end else if (ex_op == OP_MTHI) begin
                        hi_we = 1'b1;
                    end else if (ex_op == OP_MTLO) begin
                        lo_we = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (mul_cnt != '0) begin
                    stall_out = 1'b1;
                end else begin
                    cmp_we     = 1'b1;
                    cmp_hi     = product[63:32];
                    cmp_lo     = product[31:0];
                    state_next = IDLE;
                end
            end
            DIV_BUSY: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (div_done) begin
                    cmp_we     = 1'b1;
                    cmp_hi     = div_result[63:32];
                    cmp_lo     = div_result[31:0];
                    state_next = IDLE;
                end else if (busy_cnt == BUSY_LAST) begin
                    state_next = IDLE;
                end else begin
                    stall_out = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counters, operand latches and the divider start level
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            mul_cnt      <= '0;
            busy_cnt     <= '0;
            mul_a        <= 32'd0;
            mul_b        <= 32'd0;
            mul_signed   <= 1'b0;
            div_start    <= 1'b0;
            div_unsigned <= 1'b0;
            div_op1      <= 32'd0;
            div_op2      <= 32'd0;
        end else begin
            state <= state_next;
            if (issue_mul) begin
                mul_a      <= ex_rs_data;
                mul_b      <= ex_rt_data;
                mul_signed <= (ex_op == OP_MULT);
                mul_cnt    <= MUL_LOAD;
            end else if (state == MUL_BUSY && mul_cnt != '0) begin
                mul_cnt <= mul_cnt - 1'b1;
            end
            if (issue_div) begin
                div_start    <= 1'b1;
                div_unsigned <= (ex_op == OP_DIVU);
                div_op1      <= ex_rs_data;
                div_op2      <= ex_rt_data;
                busy_cnt     <= '0;
            end else if (state == DIV_BUSY) begin
                if (state_next == IDLE) div_start <= 1'b0;
                else                    busy_cnt  <= busy_cnt + 1'b1;
            end
        end
    end

    hilo_regs u_hilo_regs (
        .clock   (clock),
        .reset   (reset),
        .cmp_we  (cmp_we),
        .cmp_hi  (cmp_hi),
        .cmp_lo  (cmp_lo),
        .hi_we   (hi_we),
        .hi_data (ex_rs_data),
        .lo_we   (lo_we),
        .lo_data (ex_rs_data),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit with a behavioural iterative
// divider (fixed latency) and an arithmetic HI/LO reference model.
module tb_muldiv_hilo_unit;
    import muldiv_pkg::*;

    localparam int MUL_CYC    = 4;
    localparam int DIV_TO     = 64;
    localparam int DIV_CYCLES = 36;

    logic        clock, reset, ex_valid, flush;
    logic [2:0]  ex_op;
    logic [31:0] ex_rs_data, ex_rt_data;
    logic        stall_out, div_start, div_unsigned;
    logic [31:0] div_op1, div_op2, hi_o, lo_o;
    logic [63:0] div_result = 64'd0;
    logic        div_done   = 1'b0;
    logic        div_hang   = 1'b0;
    int          dv_cnt     = 0;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] ref_hi = 32'd0, ref_lo = 32'd0;
    logic [63:0] exp_q[$];

    // monitor state for the divider handshake
    logic        mon_prev = 1'b0;
    int          mon_low_run = 0, mon_last_gap = -1, mon_rises = 0, mon_stab_err = 0;
    logic [31:0] mon_op1 = 32'd0, mon_op2 = 32'd0;
    logic        mon_uns = 1'b0;

    muldiv_hilo_unit #(.MUL_CYCLES(MUL_CYC), .DIV_TIMEOUT(DIV_TO)) dut (
        .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .flush(flush),
        .stall_out(stall_out), .div_start(div_start), .div_unsigned(div_unsigned),
        .div_op1(div_op1), .div_op2(div_op2), .div_result(div_result),
        .div_done(div_done), .hi_o(hi_o), .lo_o(lo_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference arithmetic ----------------
    function automatic logic [63:0] ref_mul(input logic is_signed, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (is_signed) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        return 64'(sa * sb);
    endfunction

    // divider contract: {remainder, quotient}; x/0 gives q=all ones, r=x
    function automatic logic [63:0] div_model(input logic uns, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (uns) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
        return {r, q};
    endfunction

    // behavioural divider: done pulse DIV_CYCLES-1 cycles after start rises
    always @(posedge clock) begin
        if (!div_start) begin
            dv_cnt   <= 0;
            div_done <= 1'b0;
        end else if (div_done) begin
            div_done <= 1'b0;
        end else begin
            dv_cnt <= dv_cnt + 1;
            if (dv_cnt == DIV_CYCLES - 2 && !div_hang) begin
                div_done   <= 1'b1;
                div_result <= div_model(div_unsigned, div_op1, div_op2);
            end
        end
    end

    // handshake monitor: start gaps and operand stability while start is high
    always @(negedge clock) begin
        if (div_start) begin
            if (!mon_prev) begin
                mon_last_gap = mon_low_run;
                mon_rises++;
            end else if (div_op1 !== mon_op1 || div_op2 !== mon_op2 || div_unsigned !== mon_uns) begin
                mon_stab_err++;
            end
            mon_op1 = div_op1;
            mon_op2 = div_op2;
            mon_uns = div_unsigned;
            mon_low_run = 0;
        end else begin
            mon_low_run++;
        end
        mon_prev = div_start;
    end

    // ---------------- driver tasks ----------------
    // Holds the instruction in EX until it is no longer stalled (or killed by
    // a flush at cycle index flush_at, 0 = issue cycle); returns stall count.
    task automatic run_instr(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                             input int flush_at, output int stalls);
        bit left;
        stalls = 0;
        left   = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clock);
            ex_valid   = 1'b1;
            ex_op      = op;
            ex_rs_data = rs;
            ex_rt_data = rt;
            flush      = (cyc == flush_at);
            #1;
            if (stall_out) stalls++;
            else begin
                left = 1'b1;
                break;
            end
        end
        if (!left) begin
            tests_run++;
            tests_failed++;
            $display("FAIL run_instr_bound: op %0d still stalled after 300 cycles", op);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            ex_valid = 1'b0;
            ex_op    = OP_NONE;
            flush    = 1'b0;
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        tests_run++;
        if ({hi_o, lo_o} !== 64'd0) begin
            tests_failed++; $display("FAIL reset_hilo: got %h want 0", {hi_o, lo_o});
        end
        tests_run++;
        if ({stall_out, div_start, div_unsigned} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_ctrl: got %b want 000", {stall_out, div_start, div_unsigned});
        end
        tests_run++;
        if ({div_op1, div_op2} !== 64'd0) begin
            tests_failed++; $display("FAIL reset_ops: got %h want 0", {div_op1, div_op2});
        end
    endtask

    task automatic test_div_signed;
        int st;
        run_instr(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, st);
        idle(1);
        tests_run++;
        if (st !== DIV_CYCLES) begin
            tests_failed++; $display("FAIL div_stall_len: got %0d want %0d", st, DIV_CYCLES);
        end
        {ref_hi, ref_lo} = 64'hFFFF_FFFF_FFFF_FFFD;
        tests_run++;
        if ({hi_o, lo_o} !== {ref_hi, ref_lo}) begin
            tests_failed++; $display("FAIL div_signed: got %h want %h", {hi_o, lo_o}, {ref_hi, ref_lo});
        end
    endtask

    task automatic test_divu_stable;
        int st;
        run_instr(OP_DIVU, 32'd100, 32'd7, -1, st);
        idle(1);
        {ref_hi, ref_lo} = {32'd2, 32'd14};
        tests_run++;
        if ({hi_o, lo_o} !== {ref_hi, ref_lo}) begin
            tests_failed++; $display("FAIL divu_result: got %h want %h", {hi_o, lo_o}, {ref_hi, ref_lo});
        end
        tests_run++;
        if (mon_stab_err !== 0) begin
            tests_failed++; $display("FAIL div_op_stable: got %0d changes want 0", mon_stab_err);
        end
    endtask

    task automatic test_mul;
        int st;
        run_instr(OP_MULT, 32'hFFFF_FFFF, 32'd2, -1, st);
        idle(1);
        tests_run++;
        if (st !== MUL_CYC) begin
            tests_failed++; $display("FAIL mul_stall_len: got %0d want %0d", st, MUL_CYC);
        end
        {ref_hi, ref_lo} = 64'hFFFF_FFFF_FFFF_FFFE;
        tests_run++;
        if ({hi_o, lo_o} !== {ref_hi, ref_lo}) begin
            tests_failed++; $display("FAIL mult: got %h want %h", {hi_o, lo_o}, {ref_hi, ref_lo});
        end
        run_instr(OP_MULTU, 32'hFFFF_FFFF, 32'd2, -1, st);
        idle(1);
        {ref_hi, ref_lo} = 64'h0000_0001_FFFF_FFFE;
        tests_run++;
        if ({hi_o, lo_o} !== {ref_hi, ref_lo}) begin
            tests_failed++; $display("FAIL multu: got %h want %h", {hi_o, lo_o}, {ref_hi, ref_lo});
        end
    endtask

    task automatic test_flush_div;
        int st;
        run_instr(OP_MTHI, 32'h1111_1111, 32'd0, -1, st);
        tests_run++;
        if (st !== 0) begin
            tests_failed++; $display("FAIL mthi_no_stall: got %0d want 0", st);
        end
        run_instr(OP_MTLO, 32'h2222_2222, 32'd0, -1, st);
        idle(1);
        {ref_hi, ref_lo} = {32'h1111_1111, 32'h2222_2222};
        tests_run++;
        if ({hi_o, lo_o} !== {ref_hi, ref_lo}) begin
            tests_failed++; $display("FAIL mthi_mtlo: got %h want %h", {hi_o, lo_o}, {ref_hi, ref_lo});
        end
        run_instr(OP_DIV, 32'd1000, 32'd3, 10, st);
        tests_run++;
        if (st !== 10) begin
            tests_failed++; $display("FAIL flush_div_stall: got %0d want 10", st);
        end
        idle(1);
        tests_run++;
        if ({div_start, stall_out} !== 2'b00) begin
            tests_failed++; $display("FAIL flush_div_ctrl: got %b want 00", {div_start, stall_out});
        end
        idle(DIV_CYCLES);
        tests_run++;
        if ({hi_o, lo_o} !== {ref_hi, ref_lo}) begin
            tests_failed++; $display("FAIL flush_div_hilo: got %h want %h", {hi_o, lo_o}, {ref_hi, ref_lo});
        end
        run_instr(OP_DIVU, 32'd9, 32'd3, -1, st);
        idle(1);
        {ref_hi, ref_lo} = {32'd0, 32'd3};
        tests_run++;
        if ({hi_o, lo_o} !== {ref_hi, ref_lo}) begin
            tests_failed++; $display("FAIL divu_after_flush: got %h want %h", {hi_o, lo_o}, {ref_hi, ref_lo});
        end
    endtask

    task automatic test_back_to_back;
        int st, rises0;
        rises0 = mon_rises;
        run_instr(OP_DIVU, 32'd100, 32'd7, -1, st);
        run_instr(OP_DIVU, 32'd50, 32'd5, -1, st);
        idle(1);
        tests_run++;
        if (mon_rises - rises0 !== 2 || mon_last_gap !== 1) begin
            tests_failed++;
            $display("FAIL b2b_start_gap: got rises %0d gap %0d want rises 2 gap 1", mon_rises - rises0, mon_last_gap);
        end
        {ref_hi, ref_lo} = {32'd0, 32'd10};
        tests_run++;
        if ({hi_o, lo_o} !== {ref_hi, ref_lo}) begin
            tests_failed++; $display("FAIL b2b_result: got %h want %h", {hi_o, lo_o}, {ref_hi, ref_lo});
        end
    endtask

    task automatic test_flush_completion;
        int st;
        run_instr(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, st);
        idle(1);
        {ref_hi, ref_lo} = {32'hFFFF_FFFE, 32'h0000_0001};
        tests_run++;
        if ({hi_o, lo_o} !== {ref_hi, ref_lo}) begin
            tests_failed++; $display("FAIL multu_max: got %h want %h", {hi_o, lo_o}, {ref_hi, ref_lo});
        end
        run_instr(OP_MTHI, 32'hA5A5_A5A5, 32'd0, -1, st);
        run_instr(OP_MTLO, 32'h5A5A_5A5A, 32'd0, -1, st);
        {ref_hi, ref_lo} = {32'hA5A5_A5A5, 32'h5A5A_5A5A};
        run_instr(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_CYC, st);
        tests_run++;
        if (st !== MUL_CYC) begin
            tests_failed++; $display("FAIL flush_cmp_stall: got %0d want %0d", st, MUL_CYC);
        end
        idle(2);
        tests_run++;
        if ({hi_o, lo_o} !== {ref_hi, ref_lo}) begin
            tests_failed++; $display("FAIL flush_cmp_hilo: got %h want %h", {hi_o, lo_o}, {ref_hi, ref_lo});
        end
    endtask

    task automatic test_div_by_zero;
        int st, rises0;
        rises0 = mon_rises;
        run_instr(OP_DIV, 32'h0000_1234, 32'd0, -1, st);
        idle(2);
`ifdef MULDIV_DIVZERO_FAST_EN
        tests_run++;
        if (st !== 0 || mon_rises !== rises0) begin
            tests_failed++; $display("FAIL divzero_fast: got stalls %0d starts %0d want 0 0", st, mon_rises - rises0);
        end
`else
        {ref_hi, ref_lo} = {32'h0000_1234, 32'hFFFF_FFFF};
        tests_run++;
        if (st !== DIV_CYCLES || mon_rises - rises0 !== 1) begin
            tests_failed++; $display("FAIL divzero_run: got stalls %0d starts %0d want %0d 1", st, mon_rises - rises0, DIV_CYCLES);
        end
`endif
        tests_run++;
        if ({hi_o, lo_o} !== {ref_hi, ref_lo}) begin
            tests_failed++; $display("FAIL divzero_hilo: got %h want %h", {hi_o, lo_o}, {ref_hi, ref_lo});
        end
    endtask

    task automatic test_flush_idle;
        int st;
        run_instr(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 0, st);
        run_instr(OP_MULT, 32'd7, 32'd9, 0, st);
        tests_run++;
        if (st !== 0) begin
            tests_failed++; $display("FAIL flush_idle_stall: got %0d want 0", st);
        end
        idle(MUL_CYC + 2);
        tests_run++;
        if ({hi_o, lo_o} !== {ref_hi, ref_lo}) begin
            tests_failed++; $display("FAIL flush_idle_hilo: got %h want %h", {hi_o, lo_o}, {ref_hi, ref_lo});
        end
    endtask

    task automatic test_timeout;
        int st;
        div_hang = 1'b1;
        run_instr(OP_DIV, 32'd77, 32'd7, -1, st);
        idle(1);
        div_hang = 1'b0;
        tests_run++;
        if (st < DIV_TO || st > DIV_TO + 1) begin
            tests_failed++; $display("FAIL timeout_len: got %0d want %0d..%0d", st, DIV_TO, DIV_TO + 1);
        end
        tests_run++;
        if (div_start !== 1'b0 || {hi_o, lo_o} !== {ref_hi, ref_lo}) begin
            tests_failed++; $display("FAIL timeout_abort: got start %b hilo %h want 0 %h", div_start, {hi_o, lo_o}, {ref_hi, ref_lo});
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clock);
        ex_valid = 1'b1; ex_op = OP_DIVU; ex_rs_data = 32'd500; ex_rt_data = 32'd4; flush = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1; ex_valid = 1'b0; ex_op = OP_NONE;
        @(negedge clock);
        reset = 1'b0;
        #1;
        ref_hi = 32'd0; ref_lo = 32'd0;
        tests_run++;
        if ({stall_out, div_start, div_op1, div_op2, hi_o, lo_o} !== 130'd0) begin
            tests_failed++; $display("FAIL reset_mid: got stall %b start %b ops %h hilo %h want all 0",
                                     stall_out, div_start, {div_op1, div_op2}, {hi_o, lo_o});
        end
        idle(DIV_CYCLES);
        tests_run++;
        if ({hi_o, lo_o} !== 64'd0) begin
            tests_failed++; $display("FAIL reset_mid_nowrite: got %h want 0", {hi_o, lo_o});
        end
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp;
        int st, exp_st;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 9);
            if ((op == OP_DIV || op == OP_DIVU) && b == 32'd0) b = 32'd1;
            if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            exp_st = 0;
            case (op)
                OP_MULT:  begin {ref_hi, ref_lo} = ref_mul(1'b1, a, b); exp_st = MUL_CYC; end
                OP_MULTU: begin {ref_hi, ref_lo} = ref_mul(1'b0, a, b); exp_st = MUL_CYC; end
                OP_DIV:   begin {ref_hi, ref_lo} = div_model(1'b0, a, b); exp_st = DIV_CYCLES; end
                OP_DIVU:  begin {ref_hi, ref_lo} = div_model(1'b1, a, b); exp_st = DIV_CYCLES; end
                OP_MTHI:  ref_hi = a;
                default:  ref_lo = a;
            endcase
            exp_q.push_back({ref_hi, ref_lo});
            run_instr(op, a, b, -1, st);
            idle(1);
            exp = exp_q.pop_front();
            tests_run++;
            if (st !== exp_st) begin
                tests_failed++; $display("FAIL rand_stall[%0d] op %0d: got %0d want %0d", i, op, st, exp_st);
            end
            tests_run++;
            if ({hi_o, lo_o} !== exp) begin
                tests_failed++; $display("FAIL rand_hilo[%0d] op %0d a %h b %h: got %h want %h", i, op, a, b, {hi_o, lo_o}, exp);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1; ex_valid = 1'b0; ex_op = OP_NONE;
        ex_rs_data = 32'd0; ex_rt_data = 32'd0; flush = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        test_reset;
        test_div_signed;
        test_divu_stable;
        test_mul;
        test_flush_div;
        test_back_to_back;
        test_flush_completion;
        test_div_by_zero;
        test_flush_idle;
        test_timeout;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- EX-stage controller for MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Latches operands, stalls the pipeline, and drives the iterative divider through its level-held start/done interface.
- Runs its own multi-cycle multiplier and owns the architectural HI/LO register pair read by MFHI/MFLO.

Parameters:
- MUL_CYCLES, 4, cycles from multiply issue to HI/LO write (>=1).
- DIV_TIMEOUT, 64, busy-cycle limit while waiting for div_done; on expiry abort, no write.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- ex_valid  in  1  EX holds a valid instruction
- ex_op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
- ex_rs_data  in  32  rs operand
- ex_rt_data  in  32  rt operand
- flush  in  1  exception/ERET flush; kills EX instruction
- stall_out  out  1  hold IF/ID/EX
- div_start  out  1  level start to divider; held high for the whole divide
- div_unsigned  out  1  divider unsigned flag
- div_op1  out  32  dividend, stable while div_start=1
- div_op2  out  32  divisor, stable while div_start=1
- div_result  in  64  {remainder, quotient} from divider
- div_done  in  1  divider completion pulse
- hi_o  out  32  HI register
- lo_o  out  32  LO register

Behaviour:
- Reset values: state IDLE, hi_o=0, lo_o=0, div_start=0, div_op1=0, div_op2=0, div_unsigned=0, stall_out=0, counters=0.
- FSM states: IDLE, MUL_BUSY, DIV_BUSY.
- IDLE, issue condition: ex_valid, op is MULT/MULTU/DIV/DIVU, and flush=0.
  - Latch rs/rt and signedness into operand registers.
  - stall_out=1 combinationally in the issue cycle.
  - Next state: MUL_BUSY (counter=MUL_CYCLES-1) or DIV_BUSY (div_start<=1).
- IDLE, MTHI/MTLO: with ex_valid=1 and flush=0, write rs_data to HI/LO at the edge. No stall.
- MUL_BUSY:
  - stall_out=1 while counter!=0; counter decrements each cycle.
  - Completion cycle (counter==0): stall_out=0; {HI,LO} <= 64-bit product; go to IDLE.
  - Product: MULT uses sign-extended 33x33 signed arithmetic; MULTU zero-extends.
- DIV_BUSY:
  - stall_out=1 until div_done=1.
  - In the div_done cycle: stall_out=0; HI<=div_result[63:32], LO<=div_result[31:0]; div_start<=0; go to IDLE.
- div_start is registered, so it is always low for at least one cycle between divides. The divider clears its stage counter in that cycle.
- Flush in any busy state:
  - Go to IDLE at the edge, div_start<=0, no HI/LO write.
  - stall_out=0 in the flush cycle.
  - Flush in the completion cycle has priority: no write.
- Flush in IDLE suppresses issue and suppresses MTHI/MTLO.
- DIV_BUSY timeout: busy counter reaches DIV_TIMEOUT -> IDLE, div_start<=0, no write.
- Reset mid-operation: return to reset values next edge, no write.
- hi_o/lo_o are register outputs. An MFHI in the cycle after completion sees the new value.

Optional Feature:
- Macro: MULDIV_DIVZERO_FAST_EN.
- Defined:
  - DIV/DIVU with rt_data==0 completes in the issue cycle without asserting div_start.
  - stall_out=0 and HI/LO are unchanged.
- Undefined: divide-by-zero runs through the divider like any divide, and the divider's result is written.

Decomposition:
- Package muldiv_pkg:
  - ex_op encodings (OP_NONE..OP_MTLO).
  - FSM state enum.
  - Default MUL_CYCLES/DIV_TIMEOUT constants.
- Sub-module hilo_regs: the HI/LO pair with write ports and write-priority rules (completion write, MTHI, MTLO).
- The FSM, multiplier and divider interface stay in muldiv_hilo_unit.

Test Plan:
1. DIV rs=0xFFFFFFF9 (-7), rt=2, with a DIV_CYCLES=36 divider -> stall_out high 36 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFD.
2. DIVU rs=100, rt=7 -> HI=2, LO=14. div_op1/div_op2 stay constant while div_start=1.
3. MULT rs=0xFFFFFFFF, rt=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE after MUL_CYCLES. MULTU with the same operands -> HI=1, LO=0xFFFFFFFE.
4. Flush 10 cycles into a DIV:
   - next cycle div_start=0 and stall_out=0;
   - HI/LO keep the prior values (preload 0x11111111/0x22222222 via MTHI/MTLO);
   - a following DIVU 9/3 gives LO=3, HI=0.
5. Back-to-back DIVU 100/7 then DIVU 50/5:
   - div_start low for exactly one cycle between the two divides;
   - final HI=0, LO=10.
6. MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=1, with flush asserted in the completion cycle -> HI/LO unchanged. Then DIV x/0: with MULDIV_DIVZERO_FAST_EN there is no stall and no div_start.
